weight_mac_b4: RTL and testbench
================================

WEIGHT_MAC_B4 -- requirements
Module: weight_mac_b4

Interface
REQ-001 The block SHALL have the following ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- w_flat  in  224  32 packed weights; weight i occupies bits [7i+6:7i]; 7-bit two's complement.
- new_weight_val  in  32  thermometer from the weight loader; bit k rising means output channel k's weights are valid on w_flat in that same cycle.
- act_flat  in  256  32 packed activations; activation i occupies bits [8i+7:8i]; unsigned.
- act_valid  in  1  activation vector offered.
- act_ready  out  1  activation vector accepted when act_valid and act_ready are both high.
- out_valid  out  1  single-cycle result strobe.
- out_ch  out  5  output channel index of the result.
- out_sum  out  20  signed dot product for out_ch.
- frame_done  out  1  single-cycle pulse after the channel-31 result.
- err_overflow  out  1  sticky flag: a weight event was dropped.

Function
REQ-002 The block SHALL register new_weight_val as nwv_q and form evt = new_weight_val & ~nwv_q.
REQ-003 On evt != 0, the block SHALL capture w_flat plus the index k of the lowest set evt bit into a one-deep pending slot on that same edge; w_flat is not valid one cycle later.
REQ-004 If evt has more than one bit set, the block SHALL keep the lowest index and set err_overflow.
REQ-005 If evt != 0 while the pending slot is full and is not being consumed on that edge, the block SHALL drop the new event and set err_overflow.
REQ-006 Activation holding: act_ready = !act_held; acceptance latches act_flat and sets act_held.
REQ-007 The engine SHALL have two states, IDLE and MAC, with a beat counter b running 0..7.
REQ-008 IDLE -> MAC occurs when the pending slot is full and act_held is set. That edge moves the pending weights and channel into working registers, clears the pending slot, clears the accumulator, and sets b = 0.
REQ-009 In MAC beat b, the block SHALL add the four products w[4b+j] * act[4b+j], j = 0..3, to the accumulator.
REQ-010 Products SHALL be signed 7-bit times zero-extended 8-bit, giving 15 bits signed, accumulated at 20 bits signed with no saturation; the worst case magnitude of 522240 fits.
REQ-011 At beat 7 the block SHALL register the final sum into out_sum and out_ch and pulse out_valid on the following cycle.
REQ-012 At beat 7, if the pending slot is full, the block SHALL load it and restart at b = 0 (back-to-back, 8 cycles per channel); otherwise it SHALL return to IDLE.
REQ-013 Latency from the event edge to out_valid SHALL be 9 cycles when the engine is idle and act_held is set.
REQ-014 A pending-slot consume and a new event on the same edge SHALL both succeed, refilling the slot without overflow.
REQ-015 When out_valid is pulsed for out_ch = 31, the block SHALL pulse frame_done in the same cycle and clear act_held so that act_ready reasserts.
REQ-016 out_sum and out_ch SHALL hold their values between strobes.
REQ-017 err_overflow SHALL clear only on reset.

Reset
REQ-018 While rst_n is low, all registers SHALL clear asynchronously: nwv_q = 0, pending slot empty, act_held = 0, state = IDLE, b = 0, accumulator = 0, out_valid = 0, out_ch = 0, out_sum = 0, frame_done = 0, err_overflow = 0.
REQ-019 Consequently act_ready SHALL read 1 in reset.
REQ-020 A reset during MAC SHALL abandon the channel with no out_valid.
REQ-021 After reset, the block SHALL treat new_weight_val bits that are already high as not new.

Structure
REQ-022 A shared package SHALL hold W_W=7, A_W=8, N_CH=32, LANES=4, BEATS=8, ACC_W=20 and the engine state enum.
REQ-023 One sub-module, weight_mac_lane, SHALL implement a single signed-by-unsigned multiply; it is instantiated four times, and an adder tree feeds the accumulator.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Act all 1, weights all 1, channel 0 event -> out_valid 9 cycles later, out_ch = 0, out_sum = 32.
- Act all 255, weights all -64 -> out_sum = -522240; all 63 -> 514080.
- Thermometer with one bit every 8 cycles for 32 channels, act preloaded -> 32 strobes 8 cycles apart, frame_done with ch 31, act_ready = 1 after, err_overflow = 0.
- Three events with no activation held -> first pends, second drops, err_overflow = 1; act then applied -> channel of first event output only.
- Bits 3 and 5 rise together -> ch 3 processed, err_overflow = 1.
- rst_n low at MAC beat 4 -> no out_valid, all outputs 0, act_ready = 1; the following event is processed normally.

Source files
------------

// File: rtl/weight_mac_b4_pkg.sv
// Shared widths, channel/beat geometry and engine state encoding for the
// 4-lane weight dot-product engine.
package weight_mac_b4_pkg;
  localparam int W_W    = 7;
  localparam int A_W    = 8;
  localparam int N_CH   = 32;
  localparam int LANES  = 4;
  localparam int BEATS  = 8;
  localparam int ACC_W  = 20;
  localparam int CH_W   = $clog2(N_CH);
  localparam int BEAT_W = $clog2(BEATS);
  localparam int PROD_W = W_W + A_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MAC  = 1'b1
  } eng_state_e;
endpackage

// File: rtl/weight_mac_lane.sv
// One signed-weight by unsigned-activation multiplier lane.
module weight_mac_lane
  import weight_mac_b4_pkg::*;
(
  input  logic signed [W_W-1:0]    w,
  input  logic        [A_W-1:0]    a,
  output logic signed [PROD_W-1:0] p
);
  logic signed [PROD_W-1:0] w_ext;
  logic signed [PROD_W-1:0] a_ext;

  // Activation gets a zero sign bit so the product stays a signed multiply.
  always_comb begin
    w_ext = PROD_W'(w);
    a_ext = PROD_W'({1'b0, a});
    p     = w_ext * a_ext;
  end
endmodule

// File: rtl/weight_mac_b4.sv
// Per-channel weight dot product: one-deep weight event slot, held activation
// vector, and an 8-beat, 4-lane multiply-accumulate engine.
module weight_mac_b4
  import weight_mac_b4_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CH*W_W-1:0]       w_flat,
  input  logic [N_CH-1:0]           new_weight_val,
  input  logic [N_CH*A_W-1:0]       act_flat,
  input  logic                      act_valid,
  output logic                      act_ready,
  output logic                      out_valid,
  output logic [CH_W-1:0]           out_ch,
  output logic signed [ACC_W-1:0]   out_sum,
  output logic                      frame_done,
  output logic                      err_overflow
);
  function automatic logic [CH_W-1:0] lowest_idx(input logic [N_CH-1:0] v);
    lowest_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (v[i]) lowest_idx = CH_W'(i);
  endfunction

  logic [N_CH-1:0]          nwv_q;
  logic                     armed_q;
  logic [N_CH-1:0]          evt_p0;
  logic                     evt_any_p0;
  logic                     evt_multi_p0;
  logic                     pend_full_p0;
  logic [N_CH*W_W-1:0]      pend_w_p0;
  logic [CH_W-1:0]          pend_ch_p0;
  logic                     act_held;
  logic [N_CH*A_W-1:0]      act_q;
  eng_state_e               state_q, state_d;
  logic                     start_p1, last_p1, frame_clr_p1;
  logic [BEAT_W-1:0]        beat_p1;
  logic [N_CH*W_W-1:0]      work_w_p1;
  logic [CH_W-1:0]          work_ch_p1;
  logic signed [ACC_W-1:0]  acc_p1, acc_next_p1, beat_sum_p1;
  logic signed [W_W-1:0]    lane_w [LANES];
  logic [A_W-1:0]           lane_a [LANES];
  logic signed [PROD_W-1:0] lane_p [LANES];
  logic signed [PROD_W:0]   sum01, sum23;
  logic signed [PROD_W+1:0] sum_all;

  // Stage p0: rising-edge detect on the loader thermometer; the first edge
  // after reset only learns the current level so stale-high bits are not new.
  always_comb begin
    evt_p0       = armed_q ? (new_weight_val & ~nwv_q) : '0;
    evt_any_p0   = |evt_p0;
    evt_multi_p0 = |(evt_p0 & (evt_p0 - N_CH'(1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nwv_q        <= '0;
      armed_q      <= 1'b0;
      pend_full_p0 <= 1'b0;
      pend_w_p0    <= '0;
      pend_ch_p0   <= '0;
      err_overflow <= 1'b0;
    end else begin
      nwv_q   <= new_weight_val;
      armed_q <= 1'b1;
      if (evt_any_p0 && (!pend_full_p0 || start_p1)) begin
        pend_full_p0 <= 1'b1;
        pend_w_p0    <= w_flat;
        pend_ch_p0   <= lowest_idx(evt_p0);
      end else if (start_p1) begin
        pend_full_p0 <= 1'b0;
      end
      if (evt_multi_p0 || (evt_any_p0 && pend_full_p0 && !start_p1))
        err_overflow <= 1'b1;
    end
  end

  assign act_ready = !act_held;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_held <= 1'b0;
      act_q    <= '0;
    end else if (act_valid && !act_held) begin
      act_held <= 1'b1;
      act_q    <= act_flat;
    end else if (frame_clr_p1) begin
      act_held <= 1'b0;
    end
  end

  // Stage p1: engine control; a last beat with a full slot chains straight
  // into the next channel without visiting IDLE.
  always_comb begin
    state_d  = state_q;
    start_p1 = 1'b0;
    last_p1  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_full_p0 && act_held) begin
          state_d  = ST_MAC;
          start_p1 = 1'b1;
        end
      end
      ST_MAC: begin
        if (beat_p1 == BEAT_W'(BEATS - 1)) begin
          last_p1 = 1'b1;
          if (pend_full_p0) start_p1 = 1'b1;
          else              state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign frame_clr_p1 = last_p1 && (work_ch_p1 == CH_W'(N_CH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      lane_w[j] = work_w_p1[(LANES * int'(beat_p1) + j) * W_W +: W_W];
      lane_a[j] = act_q[(LANES * int'(beat_p1) + j) * A_W +: A_W];
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    weight_mac_lane u_lane (
      .w (lane_w[j]),
      .a (lane_a[j]),
      .p (lane_p[j])
    );
  end

  always_comb begin
    sum01       = (PROD_W + 1)'(lane_p[0]) + (PROD_W + 1)'(lane_p[1]);
    sum23       = (PROD_W + 1)'(lane_p[2]) + (PROD_W + 1)'(lane_p[3]);
    sum_all     = (PROD_W + 2)'(sum01) + (PROD_W + 2)'(sum23);
    beat_sum_p1 = ACC_W'(sum_all);
    acc_next_p1 = acc_p1 + beat_sum_p1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_p1    <= '0;
      acc_p1     <= '0;
      work_w_p1  <= '0;
      work_ch_p1 <= '0;
    end else if (start_p1) begin
      beat_p1    <= '0;
      acc_p1     <= '0;
      work_w_p1  <= pend_w_p0;
      work_ch_p1 <= pend_ch_p0;
    end else if (state_q == ST_MAC) begin
      beat_p1 <= beat_p1 + BEAT_W'(1);
      acc_p1  <= acc_next_p1;
    end
  end

  // Stage p2: result registers, held between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_sum    <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= last_p1;
      frame_done <= frame_clr_p1;
      if (last_p1) begin
        out_ch  <= work_ch_p1;
        out_sum <= acc_next_p1;
      end
    end
  end
endmodule

// File: tb/tb_weight_mac_b4.sv
// Randomized and directed bench for weight_mac_b4 with a dot-product
// scoreboard computed from plain integer weight/activation arrays.
module tb_weight_mac_b4;
  import weight_mac_b4_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [N_CH*W_W-1:0]     w_flat;
  logic [N_CH-1:0]         new_weight_val;
  logic [N_CH*A_W-1:0]     act_flat;
  logic                    act_valid;
  logic                    act_ready;
  logic                    out_valid;
  logic [CH_W-1:0]         out_ch;
  logic signed [ACC_W-1:0] out_sum;
  logic                    frame_done;
  logic                    err_overflow;

  weight_mac_b4 dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .w_flat         (w_flat),
    .new_weight_val (new_weight_val),
    .act_flat       (act_flat),
    .act_valid      (act_valid),
    .act_ready      (act_ready),
    .out_valid      (out_valid),
    .out_ch         (out_ch),
    .out_sum        (out_sum),
    .frame_done     (frame_done),
    .err_overflow   (err_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int wv [N_CH];
  int av [N_CH];
  int exp_ch [$];
  int exp_sum [$];
  int strobe_cyc [$];
  int mon_ch, mon_sum;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [N_CH*W_W-1:0] pack_w();
    logic [N_CH*W_W-1:0] r;
    for (int i = 0; i < N_CH; i++) r[i*W_W +: W_W] = W_W'(wv[i]);
    return r;
  endfunction

  function automatic logic [N_CH*A_W-1:0] pack_a();
    logic [N_CH*A_W-1:0] r;
    for (int i = 0; i < N_CH; i++) r[i*A_W +: A_W] = A_W'(av[i]);
    return r;
  endfunction

  function automatic int dot();
    int s = 0;
    for (int i = 0; i < N_CH; i++) s += wv[i] * av[i];
    return s;
  endfunction

  task automatic rand_w();
    for (int i = 0; i < N_CH; i++) wv[i] = int'($urandom_range(127, 0)) - 64;
  endtask

  task automatic rand_a();
    for (int i = 0; i < N_CH; i++) av[i] = int'($urandom_range(255, 0));
  endtask

  // Every result strobe must match the oldest outstanding expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      strobe_cyc.push_back(cyc);
      if (exp_ch.size() == 0) begin
        chk("unexpected_strobe_ch", int'(out_ch), -1);
      end else begin
        mon_ch  = exp_ch.pop_front();
        mon_sum = exp_sum.pop_front();
        chk("out_ch", int'(out_ch), mon_ch);
        chk("out_sum", int'(out_sum), mon_sum);
        chk("frame_done", int'(frame_done), int'(mon_ch == N_CH - 1));
      end
    end
  end

  task automatic fire(input logic [N_CH-1:0] mask, input bit push);
    int ch = 0;
    for (int i = N_CH - 1; i >= 0; i--) if (mask[i]) ch = i;
    @(negedge clk);
    if ((new_weight_val & mask) != '0) begin
      new_weight_val = new_weight_val & ~mask;
      @(negedge clk);
    end
    w_flat = pack_w();
    new_weight_val = new_weight_val | mask;
    if (push) begin
      exp_ch.push_back(ch);
      exp_sum.push_back(dot());
    end
    @(negedge clk);
    w_flat = {7{$urandom()}};
  endtask

  task automatic give_act();
    bit ok = 1'b0;
    @(negedge clk);
    act_flat  = pack_a();
    act_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (act_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    act_valid = 1'b0;
    act_flat  = {8{$urandom()}};
    chk("act_accept", int'(ok), 1);
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) break;
    end
  endtask

  task automatic reset_dut();
    chk("results_outstanding", exp_ch.size(), 0);
    @(negedge clk);
    rst_n = 1'b0;
    act_valid = 1'b0;
    new_weight_val = '0;
    repeat (2) @(negedge clk);
    exp_ch.delete();
    exp_sum.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, base;
    rst_n = 1'b0;
    w_flat = '0;
    new_weight_val = 32'h0000_0080;
    act_flat = '0;
    act_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_act_ready", int'(act_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_err", int'(err_overflow), 0);
    rst_n = 1'b1;

    // Unit weights and activations; bit 7 already high at reset is not an event.
    for (int i = 0; i < N_CH; i++) begin wv[i] = 1; av[i] = 1; end
    give_act();
    repeat (12) @(negedge clk);
    chk("s1_no_spurious", strobe_cyc.size(), 0);
    fire(32'h1, 1'b1);
    wait_strobe(n);
    chk("s1_latency", n, 9);
    repeat (10) @(negedge clk);
    chk("s1_hold_sum", int'(out_sum), 32);
    chk("s1_hold_ch", int'(out_ch), 0);

    // Extreme magnitudes.
    reset_dut();
    base = strobe_cyc.size();
    for (int i = 0; i < N_CH; i++) begin wv[i] = -64; av[i] = 255; end
    give_act();
    fire(32'h2, 1'b1);
    repeat (14) @(negedge clk);
    for (int i = 0; i < N_CH; i++) wv[i] = 63;
    fire(32'h4, 1'b1);
    repeat (14) @(negedge clk);
    chk("s2_strobes", strobe_cyc.size() - base, 2);
    chk("s2_hold_sum", int'(out_sum), 514080);

    // Thermometer sweep of all channels, one new bit every 8 cycles.
    reset_dut();
    base = strobe_cyc.size();
    rand_a();
    give_act();
    for (int k = 0; k < N_CH; k++) begin
      rand_w();
      fire(N_CH'(1) << k, 1'b1);
      if (k < N_CH - 1) repeat (6) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    chk("s3_strobes", strobe_cyc.size() - base, 32);
    for (int k = 1; k < 32 && base + k < strobe_cyc.size(); k++)
      chk("s3_spacing", strobe_cyc[base + k] - strobe_cyc[base + k - 1], 8);
    chk("s3_act_ready", int'(act_ready), 1);
    chk("s3_err", int'(err_overflow), 0);

    // Events with no activation held: first pends, later ones drop.
    reset_dut();
    base = strobe_cyc.size();
    rand_a();
    rand_w();
    fire(32'h10, 1'b1);
    chk("s4_err_first", int'(err_overflow), 0);
    rand_w();
    fire(32'h20, 1'b0);
    chk("s4_err_drop", int'(err_overflow), 1);
    rand_w();
    fire(32'h40, 1'b0);
    repeat (4) @(negedge clk);
    chk("s4_no_strobe_yet", strobe_cyc.size() - base, 0);
    give_act();
    repeat (16) @(negedge clk);
    chk("s4_strobes", strobe_cyc.size() - base, 1);
    chk("s4_err_sticky", int'(err_overflow), 1);

    // Two simultaneous rising bits.
    reset_dut();
    base = strobe_cyc.size();
    rand_a();
    give_act();
    rand_w();
    fire(32'h28, 1'b1);
    repeat (14) @(negedge clk);
    chk("s5_strobes", strobe_cyc.size() - base, 1);
    chk("s5_err", int'(err_overflow), 1);

    // Reset in the middle of a channel.
    reset_dut();
    base = strobe_cyc.size();
    rand_a();
    give_act();
    rand_w();
    fire(32'h200, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("s6_out_valid", int'(out_valid), 0);
    chk("s6_out_ch", int'(out_ch), 0);
    chk("s6_out_sum", int'(out_sum), 0);
    chk("s6_frame_done", int'(frame_done), 0);
    chk("s6_err", int'(err_overflow), 0);
    chk("s6_act_ready", int'(act_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("s6_abandoned", strobe_cyc.size() - base, 0);
    rand_a();
    give_act();
    rand_w();
    fire(32'h400, 1'b1);
    wait_strobe(n);
    chk("s6_latency", n, 9);
    repeat (4) @(negedge clk);

    // Randomized channels, activations and spacing.
    for (int r = 0; r < 2; r++) begin
      reset_dut();
      rand_a();
      give_act();
      for (int e = 0; e < 12; e++) begin
        rand_w();
        fire(N_CH'(1) << $urandom_range(N_CH - 2, 0), 1'b1);
        repeat ($urandom_range(10, 6)) @(negedge clk);
      end
      repeat (16) @(negedge clk);
      chk("s7_err", int'(err_overflow), 0);
    end

    chk("queue_drained", exp_ch.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
